// File: rtl/if_id_stage_if.sv
// Fetch-stage bundle: hazard-unit controls, EX/ID redirects, instruction memory
// and the IF/ID register outputs consumed by decode.
interface if_id_stage_if #(
  parameter int CNT_W = 16
);
  logic             PC_Wr_en;
  logic             IF_ID_Wr_en;
  logic             IF_ID_flush;
  logic             branch_taken;
  logic [31:0]      branch_target;
  logic             jump_en;
  logic [31:0]      jump_target;
  logic [31:0]      imem_instr;
  logic [31:0]      imem_addr;
  logic [31:0]      IF_ID_instr;
  logic [31:0]      IF_ID_PC_plus4;
  logic             IF_ID_valid;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output PC_Wr_en, IF_ID_Wr_en, IF_ID_flush, branch_taken, branch_target,
           jump_en, jump_target, imem_instr,
    input  imem_addr, IF_ID_instr, IF_ID_PC_plus4, IF_ID_valid, stall_cnt, flush_cnt
  );

  modport slave (
    input  PC_Wr_en, IF_ID_Wr_en, IF_ID_flush, branch_taken, branch_target,
           jump_en, jump_target, imem_instr,
    output imem_addr, IF_ID_instr, IF_ID_PC_plus4, IF_ID_valid, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/if_id_stage.sv
// MIPS pipeline front end: PC register, next-PC selection, IF/ID register with
// stall/flush, and saturating stall/flush event counters.
module if_id_stage #(
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic         clk,
  input  logic         reset,
  if_id_stage_if.slave bus
);

  logic [31:0]      pc;
  logic [31:0]      pc_next;
  logic [31:0]      pc_plus4;
  logic [31:0]      ifid_instr;
  logic [31:0]      ifid_pc4;
  logic             ifid_valid;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  assign pc_plus4 = pc + 32'd4;

  // A taken branch overrides a PC stall; a jump waits until the stall clears.
  always_comb begin
    pc_next = pc;
    if (bus.branch_taken)
      pc_next = bus.branch_target;
    else if (bus.PC_Wr_en)
      pc_next = bus.jump_en ? bus.jump_target : pc_plus4;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pc <= PC_RESET;
    else
      pc <= pc_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifid_instr <= NOP_INSTR;
      ifid_pc4   <= PC_RESET;
      ifid_valid <= 1'b0;
    end else if (bus.IF_ID_flush) begin
      ifid_instr <= NOP_INSTR;
      ifid_pc4   <= '0;
      ifid_valid <= 1'b0;
    end else if (bus.IF_ID_Wr_en) begin
      ifid_instr <= bus.imem_instr;
      ifid_pc4   <= pc_plus4;
      ifid_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (bus.IF_ID_flush) begin
        if (flush_cnt != '1)
          flush_cnt <= flush_cnt + 1'b1;
      end else if (!bus.IF_ID_Wr_en) begin
        if (stall_cnt != '1)
          stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

  assign bus.imem_addr      = pc;
  assign bus.IF_ID_instr    = ifid_instr;
  assign bus.IF_ID_PC_plus4 = ifid_pc4;
  assign bus.IF_ID_valid    = ifid_valid;
  assign bus.stall_cnt      = stall_cnt;
  assign bus.flush_cnt      = flush_cnt;

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed vector table, randomized run
// against a behavioural model, and a narrow-counter / wrap / async-reset instance.
module tb_if_id_stage;

  logic clk;
  logic rst;
  logic rst2;

  int unsigned n_checks;
  int unsigned n_fail;

  if_id_stage_if #(.CNT_W(16)) b  ();
  if_id_stage_if #(.CNT_W(4))  b2 ();

  if_id_stage #(.PC_RESET(32'h0000_0000), .NOP_INSTR(32'h0000_0000), .CNT_W(16))
    dut (.clk(clk), .reset(rst), .bus(b.slave));

  if_id_stage #(.PC_RESET(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0000), .CNT_W(4))
    dut_sat (.clk(clk), .reset(rst2), .bus(b2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        pcw, ifw, fl, br;
    logic [31:0] bt;
    logic        j;
    logic [31:0] jt, im;
    logic [31:0] e_addr, e_instr, e_pc4;
    logic        e_valid;
    int          e_stall, e_flush;
  } vec_t;

  function automatic vec_t mk(logic pcw, logic ifw, logic fl, logic br, logic [31:0] bt,
                              logic j, logic [31:0] jt, logic [31:0] im,
                              logic [31:0] ea, logic [31:0] ei, logic [31:0] ep,
                              logic ev, int es, int ef);
    vec_t v;
    v.pcw = pcw; v.ifw = ifw; v.fl = fl; v.br = br; v.bt = bt;
    v.j = j; v.jt = jt; v.im = im;
    v.e_addr = ea; v.e_instr = ei; v.e_pc4 = ep; v.e_valid = ev;
    v.e_stall = es; v.e_flush = ef;
    return v;
  endfunction

  task automatic drive(input logic pcw, input logic ifw, input logic fl, input logic br,
                       input logic [31:0] bt, input logic j, input logic [31:0] jt,
                       input logic [31:0] im);
    b.PC_Wr_en = pcw; b.IF_ID_Wr_en = ifw; b.IF_ID_flush = fl; b.branch_taken = br;
    b.branch_target = bt; b.jump_en = j; b.jump_target = jt; b.imem_instr = im;
  endtask

  task automatic chk_main(input string tag, input logic [31:0] ea, input logic [31:0] ei,
                          input logic [31:0] ep, input logic ev, input int es, input int ef);
    chk({tag, ".addr"},  b.imem_addr, ea);
    chk({tag, ".instr"}, b.IF_ID_instr, ei);
    chk({tag, ".pc4"},   b.IF_ID_PC_plus4, ep);
    chk({tag, ".valid"}, {31'b0, b.IF_ID_valid}, {31'b0, ev});
    chk({tag, ".stall"}, {16'b0, b.stall_cnt}, es);
    chk({tag, ".flush"}, {16'b0, b.flush_cnt}, ef);
  endtask

  // Behavioural reference state for the randomized run.
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  longint      m_stall, m_flush;

  vec_t tbl[18];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst  = 1'b1;
    rst2 = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, '0);
    b2.PC_Wr_en = 1'b1; b2.IF_ID_Wr_en = 1'b1; b2.IF_ID_flush = 1'b0;
    b2.branch_taken = 1'b0; b2.branch_target = '0; b2.jump_en = 1'b0;
    b2.jump_target = '0; b2.imem_instr = 32'h0000_1234;

    //           pcw ifw fl br bt            j  jt            im             addr          instr         pc4           v  st fl
    tbl[0]  = mk(1, 1, 0, 0, 32'h0,        0, 32'h0,        32'h2008_0001, 32'h0000_0004, 32'h2008_0001, 32'h0000_0004, 1, 0, 0);
    tbl[1]  = mk(1, 1, 0, 0, 32'h0,        0, 32'h0,        32'h2008_0002, 32'h0000_0008, 32'h2008_0002, 32'h0000_0008, 1, 0, 0);
    tbl[2]  = mk(1, 1, 0, 0, 32'h0,        0, 32'h0,        32'h2008_0003, 32'h0000_000C, 32'h2008_0003, 32'h0000_000C, 1, 0, 0);
    tbl[3]  = mk(1, 1, 0, 0, 32'h0,        0, 32'h0,        32'h2008_0004, 32'h0000_0010, 32'h2008_0004, 32'h0000_0010, 1, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'hDEAD_BEEF, 32'h0000_0010, 32'h2008_0004, 32'h0000_0010, 1, 1, 0);
    tbl[5]  = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'hDEAD_BEEF, 32'h0000_0010, 32'h2008_0004, 32'h0000_0010, 1, 2, 0);
    tbl[6]  = mk(1, 1, 0, 0, 32'h0,        0, 32'h0,        32'h2008_0005, 32'h0000_0014, 32'h2008_0005, 32'h0000_0014, 1, 2, 0);
    tbl[7]  = mk(1, 1, 0, 0, 32'h0,        0, 32'h0,        32'h2008_0006, 32'h0000_0018, 32'h2008_0006, 32'h0000_0018, 1, 2, 0);
    tbl[8]  = mk(1, 1, 0, 0, 32'h0,        0, 32'h0,        32'h2008_0007, 32'h0000_001C, 32'h2008_0007, 32'h0000_001C, 1, 2, 0);
    tbl[9]  = mk(1, 1, 0, 0, 32'h0,        0, 32'h0,        32'h2008_0008, 32'h0000_0020, 32'h2008_0008, 32'h0000_0020, 1, 2, 0);
    tbl[10] = mk(0, 0, 1, 1, 32'h100,      0, 32'h0,        32'h2008_0009, 32'h0000_0100, 32'h0000_0000, 32'h0000_0000, 0, 2, 1);
    tbl[11] = mk(0, 0, 0, 0, 32'h0,        1, 32'h200,      32'h2008_000A, 32'h0000_0100, 32'h0000_0000, 32'h0000_0000, 0, 3, 1);
    tbl[12] = mk(1, 1, 0, 0, 32'h0,        1, 32'h200,      32'h2008_000B, 32'h0000_0200, 32'h2008_000B, 32'h0000_0104, 1, 3, 1);
    tbl[13] = mk(1, 1, 1, 0, 32'h0,        0, 32'h0,        32'h2008_000C, 32'h0000_0204, 32'h0000_0000, 32'h0000_0000, 0, 3, 2);
    tbl[14] = mk(1, 1, 0, 1, 32'hFFFF_FFFC, 0, 32'h0,       32'h2008_000D, 32'hFFFF_FFFC, 32'h2008_000D, 32'h0000_0208, 1, 3, 2);
    tbl[15] = mk(1, 1, 0, 0, 32'h0,        0, 32'h0,        32'h2008_000E, 32'h0000_0000, 32'h2008_000E, 32'h0000_0000, 1, 3, 2);
    tbl[16] = mk(0, 1, 0, 1, 32'h40,       1, 32'h300,      32'h2008_000F, 32'h0000_0040, 32'h2008_000F, 32'h0000_0004, 1, 3, 2);
    tbl[17] = mk(1, 0, 1, 0, 32'h0,        0, 32'h0,        32'h2008_0010, 32'h0000_0044, 32'h0000_0000, 32'h0000_0000, 0, 3, 3);

    #12;
    chk_main("reset", 32'h0, 32'h0, 32'h0, 1'b0, 0, 0);
    chk("sat_reset.addr", b2.imem_addr, 32'hFFFF_FFFC);

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].pcw, tbl[i].ifw, tbl[i].fl, tbl[i].br, tbl[i].bt, tbl[i].j, tbl[i].jt, tbl[i].im);
      @(posedge clk);
      #1;
      chk_main($sformatf("vec%0d", i), tbl[i].e_addr, tbl[i].e_instr, tbl[i].e_pc4,
               tbl[i].e_valid, tbl[i].e_stall, tbl[i].e_flush);
    end

    // Randomized run from a fresh reset against the reference model.
    @(negedge clk);
    rst = 1'b1;
    #1;
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_stall = 0; m_flush = 0;
    chk_main("rreset", m_pc, m_instr, m_pc4, m_valid, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic pcw, ifw, fl, br, j;
      logic [31:0] bt, jt, im;
      pcw = ($urandom_range(0, 3) != 0);
      ifw = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 4) == 0);
      br  = ($urandom_range(0, 6) == 0);
      j   = ($urandom_range(0, 4) == 0);
      bt  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC)) : $urandom;
      jt  = $urandom;
      im  = $urandom;
      drive(pcw, ifw, fl, br, bt, j, jt, im);
      // IF/ID update uses the current PC; PC update follows the redirect priorities.
      if (fl) begin
        m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        m_flush = (m_flush + 1 > 65535) ? 65535 : m_flush + 1;
      end else if (!ifw) begin
        m_stall = (m_stall + 1 > 65535) ? 65535 : m_stall + 1;
      end else begin
        m_instr = im; m_pc4 = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000); m_valid = 1'b1;
      end
      if (br)            m_pc = bt;
      else if (pcw && j) m_pc = jt;
      else if (pcw)      m_pc = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
      @(posedge clk);
      #1;
      chk_main("rand", m_pc, m_instr, m_pc4, m_valid, int'(m_stall), int'(m_flush));
    end

    // Narrow counters, PC wrap from a high reset vector, async reset mid-stall.
    @(negedge clk);
    rst2 = 1'b0;
    @(posedge clk);
    #1;
    chk("wrap.addr",  b2.imem_addr, 32'h0000_0000);
    chk("wrap.pc4",   b2.IF_ID_PC_plus4, 32'h0000_0000);
    chk("wrap.instr", b2.IF_ID_instr, 32'h0000_1234);
    b2.PC_Wr_en = 1'b0;
    b2.IF_ID_Wr_en = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("sat.stall%0d", i), {28'b0, b2.stall_cnt}, (i > 15) ? 32'd15 : i);
    end
    chk("sat.addr_held", b2.imem_addr, 32'h0000_0000);
    b2.IF_ID_flush = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("sat.flush%0d", i), {28'b0, b2.flush_cnt}, (i > 15) ? 32'd15 : i);
    end
    chk("sat.stall_kept", {28'b0, b2.stall_cnt}, 32'd15);
    b2.IF_ID_flush = 1'b0;
    @(posedge clk);
    #3;
    rst2 = 1'b1;
    #1;
    chk("arst.addr",  b2.imem_addr, 32'hFFFF_FFFC);
    chk("arst.instr", b2.IF_ID_instr, 32'h0000_0000);
    chk("arst.pc4",   b2.IF_ID_PC_plus4, 32'hFFFF_FFFC);
    chk("arst.valid", {31'b0, b2.IF_ID_valid}, 32'd0);
    chk("arst.stall", {28'b0, b2.stall_cnt}, 32'd0);
    chk("arst.flush", {28'b0, b2.flush_cnt}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
